// File: rtl/core_run_controller_if.sv
// Control/status bundle between a run driver (bench or debug logic) and core_run_controller.
// The controller uses the slave modport; whatever sequences runs uses the master modport.
interface core_run_controller_if #(
  parameter int CycleWidth = 16
);
  logic                  start;
  logic                  abort;
  logic [1:0]            mode;
  logic [CycleWidth-1:0] cycle_limit;
  logic                  step;
  logic                  halt_in;
  logic                  core_rst;
  logic                  core_en;
  logic [CycleWidth-1:0] cycle_count;
  logic                  busy;
  logic                  done;
  logic                  timeout;

  modport master (
    output start, abort, mode, cycle_limit, step, halt_in,
    input  core_rst, core_en, cycle_count, busy, done, timeout
  );

  modport slave (
    input  start, abort, mode, cycle_limit, step, halt_in,
    output core_rst, core_en, cycle_count, busy, done, timeout
  );
endinterface

// File: rtl/core_run_controller.sv
// Run/sequencing controller for core_top: owns the core reset and clock-enable and runs the core
// for a fixed cycle count, until halt (with optional watchdog), or one step at a time.
module core_run_controller #(
  parameter int CycleWidth  = 16,
  parameter int ResetCycles = 2
) (
  input logic                  clk,
  input logic                  rst,
  core_run_controller_if.slave bus
);

  localparam int              RstW    = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
  localparam logic [RstW-1:0] RstLast = RstW'(ResetCycles - 1);

  localparam logic [1:0] ModeRunN = 2'b00;
  localparam logic [1:0] ModeStep = 2'b10;

  typedef enum logic [2:0] {IDLE, RESET, RUN, STEP, DONE} state_t;

  state_t                state_q, state_n;
  logic [1:0]            mode_q, mode_n;
  logic [CycleWidth-1:0] limit_q, limit_n;
  logic [CycleWidth-1:0] count_q, count_n;
  logic [RstW-1:0]       rst_cnt_q, rst_cnt_n;
  logic                  core_rst_q, core_rst_n;
  logic                  core_en_q, core_en_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  timeout_q, timeout_n;

  logic [CycleWidth-1:0] count_inc;
  logic                  halt_hit;
  logic                  limit_hit;

  // Cycle counter never wraps; it sticks at all-ones when no watchdog bounds the run.
  function automatic logic [CycleWidth-1:0] sat_inc(input logic [CycleWidth-1:0] v);
    return (v == '1) ? v : v + CycleWidth'(1);
  endfunction

  assign count_inc = sat_inc(count_q);
  assign halt_hit  = core_en_q && bus.halt_in && (mode_q != ModeRunN);
  assign limit_hit = core_en_q && (limit_q != '0) && (count_inc == limit_q);

  always_comb begin
    state_n    = state_q;
    mode_n     = mode_q;
    limit_n    = limit_q;
    count_n    = count_q;
    rst_cnt_n  = rst_cnt_q;
    core_rst_n = core_rst_q;
    core_en_n  = core_en_q;
    done_n     = done_q;
    timeout_n  = timeout_q;

    if (bus.abort) begin
      // Abort freezes the count so the caller can see how far the run got.
      state_n    = IDLE;
      core_rst_n = 1'b1;
      core_en_n  = 1'b0;
      done_n     = 1'b0;
      timeout_n  = 1'b0;
    end else begin
      if (core_en_q) begin
        count_n = count_inc;
      end
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_n    = RESET;
            mode_n     = (bus.mode == 2'b11) ? ModeRunN : bus.mode;
            limit_n    = bus.cycle_limit;
            count_n    = '0;
            rst_cnt_n  = '0;
            core_rst_n = 1'b1;
            core_en_n  = 1'b0;
            done_n     = 1'b0;
            timeout_n  = 1'b0;
          end
        end
        RESET: begin
          if (rst_cnt_q == RstLast) begin
            core_rst_n = 1'b0;
            if (mode_q == ModeRunN && limit_q == '0) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else if (mode_q == ModeStep) begin
              state_n = STEP;
            end else begin
              state_n   = RUN;
              core_en_n = 1'b1;
            end
          end else begin
            rst_cnt_n = rst_cnt_q + RstW'(1);
          end
        end
        RUN, STEP: begin
          // Halt beats the limit when both land on the same enabled cycle.
          if (halt_hit) begin
            state_n   = DONE;
            core_en_n = 1'b0;
            done_n    = 1'b1;
          end else if (limit_hit) begin
            state_n   = DONE;
            core_en_n = 1'b0;
            done_n    = 1'b1;
            timeout_n = (mode_q != ModeRunN);
          end else if (state_q == STEP) begin
            // One enabled cycle per request; a step seen during that cycle is dropped.
            core_en_n = !core_en_q && bus.step;
          end
        end
        default: begin
          state_n    = IDLE;
          core_rst_n = 1'b1;
          core_en_n  = 1'b0;
        end
      endcase
    end

    busy_n = (state_n == RESET) || (state_n == RUN) || (state_n == STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rst_cnt_q  <= '0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      rst_cnt_q  <= rst_cnt_n;
      core_rst_q <= core_rst_n;
      core_en_q  <= core_en_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      timeout_q  <= timeout_n;
    end
  end

  // Run configuration is only consulted after a start loads it, so it needs no reset.
  always_ff @(posedge clk) begin
    mode_q  <= mode_n;
    limit_q <= limit_n;
  end

  assign bus.core_rst    = core_rst_q;
  assign bus.core_en     = core_en_q;
  assign bus.cycle_count = count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller: run-N, run-until-halt, watchdog, single-step,
// zero-length runs, ignored starts, abort and asynchronous reset.
module tb_core_run_controller;
  localparam int CW = 16;
  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  core_run_controller_if #(.CycleWidth(CW)) bus ();

  core_run_controller #(.CycleWidth(CW), .ResetCycles(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {core_rst, core_en, busy, done, timeout}
  function automatic logic [4:0] status();
    return {bus.core_rst, bus.core_en, bus.busy, bus.done, bus.timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scrambles mode/limit after the start edge so a missing latch shows up.
  task automatic do_start(input logic [1:0] m, input logic [CW-1:0] lim);
    bus.mode        = m;
    bus.cycle_limit = lim;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.mode        = m ^ 2'b01;
    bus.cycle_limit = ~lim;
  endtask

  // Samples once per cycle until done; halt_in is raised during the halt_at-th enabled cycle.
  task automatic run_until_done(input int halt_at, input logic [31:0] step_pat, input int max_cyc,
                                output int n_en, output int n_rst, output bit ok);
    n_en  = 0;
    n_rst = 0;
    ok    = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (bus.core_rst === 1'b1) n_rst++;
      if (bus.core_en === 1'b1) n_en++;
      bus.halt_in = (bus.core_en === 1'b1) && (n_en == halt_at);
      bus.step    = (i < 32) ? step_pat[i] : 1'b0;
      tick();
    end
    bus.halt_in = 1'b0;
    bus.step    = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (status() !== 5'b10000) begin errors++; $display("FAIL reset_async status got %b exp %b", status(), 5'b10000); end
    checks++;
    if (bus.cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.cycle_count); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (status() !== 5'b10000) begin errors++; $display("FAIL reset_idle status got %b exp %b", status(), 5'b10000); end
  endtask

  task automatic test_run_n();
    int n_en, n_rst; bit ok;
    do_start(2'b00, 16'd5);
    checks++;
    if (status() !== 5'b10100) begin errors++; $display("FAIL run_n_start status got %b exp %b", status(), 5'b10100); end
    run_until_done(0, 32'd0, 40, n_en, n_rst, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL run_n_done got 0 exp 1"); end
    checks++;
    if (n_rst != RC) begin errors++; $display("FAIL run_n_rst_cycles got %0d exp %0d", n_rst, RC); end
    checks++;
    if (n_en != 5) begin errors++; $display("FAIL run_n_en_cycles got %0d exp 5", n_en); end
    checks++;
    if (status() !== 5'b00010) begin errors++; $display("FAIL run_n_status got %b exp %b", status(), 5'b00010); end
    checks++;
    if (bus.cycle_count !== 16'd5) begin errors++; $display("FAIL run_n_count got %0d exp 5", bus.cycle_count); end
    // Halt is not a stop condition for a fixed-count run; mode 11 behaves as 00.
    do_start(2'b11, 16'd3);
    run_until_done(1, 32'd0, 40, n_en, n_rst, ok);
    checks++;
    if (!ok || n_en != 3 || bus.cycle_count !== 16'd3 || status() !== 5'b00010) begin
      errors++; $display("FAIL run_n_mode3 got en=%0d count=%0d st=%b exp en=3 count=3 st=00010", n_en, bus.cycle_count, status());
    end
  endtask

  task automatic test_halt();
    int n_en, n_rst; bit ok;
    do_start(2'b01, 16'd100);
    run_until_done(7, 32'd0, 200, n_en, n_rst, ok);
    checks++;
    if (!ok || n_en != 7) begin errors++; $display("FAIL halt_en_cycles got %0d exp 7", n_en); end
    checks++;
    if (bus.cycle_count !== 16'd7) begin errors++; $display("FAIL halt_count got %0d exp 7", bus.cycle_count); end
    checks++;
    if (status() !== 5'b00010) begin errors++; $display("FAIL halt_status got %b exp %b", status(), 5'b00010); end
  endtask

  task automatic test_watchdog();
    int n_en, n_rst; bit ok;
    do_start(2'b01, 16'd100);
    run_until_done(0, 32'd0, 200, n_en, n_rst, ok);
    checks++;
    if (!ok || n_en != 100) begin errors++; $display("FAIL wdog_en_cycles got %0d exp 100", n_en); end
    checks++;
    if (bus.cycle_count !== 16'd100) begin errors++; $display("FAIL wdog_count got %0d exp 100", bus.cycle_count); end
    checks++;
    if (status() !== 5'b00011) begin errors++; $display("FAIL wdog_status got %b exp %b", status(), 5'b00011); end
    // Abort out of DONE clears done and timeout.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (status() !== 5'b10000) begin errors++; $display("FAIL wdog_abort_clear got %b exp %b", status(), 5'b10000); end
    do_start(2'b01, 16'd4);
    run_until_done(4, 32'd0, 40, n_en, n_rst, ok);
    checks++;
    if (!ok || bus.cycle_count !== 16'd4 || status() !== 5'b00010) begin
      errors++; $display("FAIL halt_wins got count=%0d st=%b exp count=4 st=00010", bus.cycle_count, status());
    end
  endtask

  task automatic test_step();
    int n_en, n_rst; bit ok;
    // Steps at samples 3, 6-7 (held two cycles) and 11; halt on the third enabled cycle.
    do_start(2'b10, 16'd0);
    run_until_done(3, 32'h0000_08C8, 40, n_en, n_rst, ok);
    checks++;
    if (!ok || n_en != 3) begin errors++; $display("FAIL step_en_cycles got %0d exp 3", n_en); end
    checks++;
    if (bus.cycle_count !== 16'd3) begin errors++; $display("FAIL step_count got %0d exp 3", bus.cycle_count); end
    checks++;
    if (status() !== 5'b00010) begin errors++; $display("FAIL step_halt_status got %b exp %b", status(), 5'b00010); end
    // Watchdog of 2 ends a stepped run on the second step with timeout.
    do_start(2'b10, 16'd2);
    run_until_done(0, 32'h0000_0048, 40, n_en, n_rst, ok);
    checks++;
    if (!ok || n_en != 2 || bus.cycle_count !== 16'd2 || status() !== 5'b00011) begin
      errors++; $display("FAIL step_wdog got en=%0d count=%0d st=%b exp en=2 count=2 st=00011", n_en, bus.cycle_count, status());
    end
  endtask

  task automatic test_zero_and_busy_start();
    int n_en, n_rst; bit ok;
    do_start(2'b00, 16'd0);
    run_until_done(0, 32'd0, 20, n_en, n_rst, ok);
    checks++;
    if (!ok || n_en != 0 || n_rst != RC) begin errors++; $display("FAIL zero_limit got en=%0d rst=%0d exp en=0 rst=%0d", n_en, n_rst, RC); end
    checks++;
    if (bus.cycle_count !== 16'd0 || status() !== 5'b00010) begin
      errors++; $display("FAIL zero_limit_state got count=%0d st=%b exp count=0 st=00010", bus.cycle_count, status());
    end
    do_start(2'b00, 16'd6);
    repeat (3) tick();
    bus.mode        = 2'b00;
    bus.cycle_limit = 16'd1;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    checks++;
    if (status() !== 5'b01100) begin errors++; $display("FAIL busy_start_ignored got %b exp %b", status(), 5'b01100); end
    run_until_done(0, 32'd0, 40, n_en, n_rst, ok);
    checks++;
    if (!ok || bus.cycle_count !== 16'd6) begin errors++; $display("FAIL busy_start_count got %0d exp 6", bus.cycle_count); end
  endtask

  task automatic test_abort();
    int n_en, n_rst; bit ok;
    do_start(2'b00, 16'd10);
    for (int i = 0; i < 20 && bus.cycle_count !== 16'd3; i++) tick();
    checks++;
    if (bus.cycle_count !== 16'd3 || bus.core_en !== 1'b1) begin
      errors++; $display("FAIL abort_reach3 got count=%0d en=%b exp count=3 en=1", bus.cycle_count, bus.core_en);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (status() !== 5'b10000) begin errors++; $display("FAIL abort_status got %b exp %b", status(), 5'b10000); end
    checks++;
    if (bus.cycle_count !== 16'd3) begin errors++; $display("FAIL abort_count_kept got %0d exp 3", bus.cycle_count); end
    // From DONE, abort and start together: abort wins.
    do_start(2'b00, 16'd1);
    run_until_done(0, 32'd0, 20, n_en, n_rst, ok);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (!ok || status() !== 5'b10000 || bus.cycle_count !== 16'd1) begin
      errors++; $display("FAIL abort_beats_start got st=%b count=%0d exp st=10000 count=1", status(), bus.cycle_count);
    end
  endtask

  task automatic test_async_rst();
    int n_en, n_rst; bit ok;
    do_start(2'b00, 16'd10);
    repeat (4) tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if (status() !== 5'b10000 || bus.cycle_count !== 16'd0) begin
      errors++; $display("FAIL async_rst got st=%b count=%0d exp st=10000 count=0", status(), bus.cycle_count);
    end
    #1 rst = 1'b0;
    tick();
    do_start(2'b00, 16'd2);
    run_until_done(0, 32'd0, 20, n_en, n_rst, ok);
    checks++;
    if (!ok || n_en != 2 || n_rst != RC || bus.cycle_count !== 16'd2 || status() !== 5'b00010) begin
      errors++; $display("FAIL rerun got en=%0d rst=%0d count=%0d st=%b exp en=2 rst=%0d count=2 st=00010",
                         n_en, n_rst, bus.cycle_count, status(), RC);
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.mode        = 2'b00;
    bus.cycle_limit = '0;
    bus.step        = 1'b0;
    bus.halt_in     = 1'b0;
    test_reset();
    test_run_n();
    test_halt();
    test_watchdog();
    test_step();
    test_zero_and_busy_start();
    test_abort();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end
endmodule
